// File: rtl/latch259_writer_pkg.sv
// Shared definitions for the 74HC259 write sequencer.
//   state_t  : FSM state encoding (IDLE = 0 .. HOLD = 4)
//   IDX_W    : width of a latch bit address
//   phase_w(): width of the shared phase down-counter for a given set of
//              phase lengths (never narrower than one bit)
package latch259_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    localparam int IDX_W = 3;

    // The counter is loaded with length-1, so clog2(longest phase) bits suffice.
    function automatic int phase_w(input int s, input int p, input int h);
        int m;
        m = s;
        if (p > m) m = p;
        if (h > m) m = h;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/latch259_writer_if.sv
// Byte handshake between the bus-side register logic and the latch writer.
//   din/mask : byte and per-bit write enables
//   valid    : din/mask valid
//   clr      : clear request (sampled only while ready)
//   ready    : writer idle and accepting
//   busy     : writer not idle
interface latch259_writer_if;
    logic [7:0] din;
    logic [7:0] mask;
    logic       valid;
    logic       clr;
    logic       ready;
    logic       busy;

    modport master (output din, mask, valid, clr, input ready, busy);
    modport slave  (input din, mask, valid, clr, output ready, busy);
endinterface

// File: rtl/latch259_writer_next_bit.sv
// Combinational priority encoder choosing the next latch bit to write.
//   mask  : bits still eligible for writing
//   cur   : index of the bit just written
//   start : 1 = pick the lowest set bit, 0 = pick the lowest set bit above cur
//   nxt   : chosen index
//   found : a qualifying bit exists
module latch259_next_bit
    import latch259_pkg::*;
(
    input  logic [7:0]       mask,
    input  logic [IDX_W-1:0] cur,
    input  logic             start,
    output logic [IDX_W-1:0] nxt,
    output logic             found
);

    // Scan downwards so the lowest qualifying index is the one left standing.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (start || (i > int'(cur)))) begin
                nxt   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/latch259_writer.sv
// Write sequencer feeding an emulated 74HC259 addressable latch.
// Accepts one byte per handshake and writes each enabled bit into the latch
// in ascending order with setup / strobe / hold phases; an optional clear
// pulses the latch master reset first.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : byte handshake (slave side)
//   a, d       : latch address and data
//   n_le       : latch enable, active low
//   n_mr       : latch master reset, active low
//
// state  | meaning
// IDLE   | ready, waiting for valid or clr
// CLEAR  | n_mr low for PULSE_CYC cycles
// SETUP  | a/d presented, n_le high, SETUP_CYC cycles
// STROBE | n_le low, PULSE_CYC cycles
// HOLD   | n_le high, a/d held, HOLD_CYC cycles
module latch259_writer
    import latch259_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    latch259_writer_if.slave bus,
    output logic [IDX_W-1:0] a,
    output logic             d,
    output logic             n_le,
    output logic             n_mr
);

    localparam int CW = phase_w(SETUP_CYC, PULSE_CYC, HOLD_CYC);
    localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] LD_PULSE = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [7:0]       din_r, mask_r;
    logic             wr_pend;
    logic             accept;
    logic [7:0]       enc_mask, enc_din;
    logic [IDX_W-1:0] nb_idx;
    logic             nb_found;

    assign accept = bus.ready && (bus.valid || bus.clr);

    // In IDLE the first bit must be chosen from the byte being accepted this
    // edge, before it lands in the capture registers.
    assign enc_mask = (state == ST_IDLE) ? bus.mask : mask_r;
    assign enc_din  = (state == ST_IDLE) ? bus.din  : din_r;

    latch259_next_bit u_next_bit (
        .mask  (enc_mask),
        .cur   (a),
        .start (state != ST_HOLD),
        .nxt   (nb_idx),
        .found (nb_found)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = a;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.clr) begin
                        state_nxt = ST_CLEAR;
                        cnt_nxt   = LD_PULSE;
                    end else if (nb_found) begin
                        state_nxt = ST_SETUP;
                        cnt_nxt   = LD_SETUP;
                        idx_nxt   = nb_idx;
                    end
                end
            end
            ST_CLEAR: begin
                if (cnt == '0) begin
                    if (wr_pend && nb_found) begin
                        state_nxt = ST_SETUP;
                        cnt_nxt   = LD_SETUP;
                        idx_nxt   = nb_idx;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_nxt = ST_STROBE;
                    cnt_nxt   = LD_PULSE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_STROBE: begin
                if (cnt == '0) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = LD_HOLD;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    if (nb_found) begin
                        state_nxt = ST_SETUP;
                        cnt_nxt   = LD_SETUP;
                        idx_nxt   = nb_idx;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change together
    // with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            a         <= '0;
            d         <= 1'b0;
            n_le      <= 1'b1;
            n_mr      <= 1'b1;
            bus.ready <= 1'b1;
            bus.busy  <= 1'b0;
            din_r     <= '0;
            mask_r    <= '0;
            wr_pend   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            if (state_nxt == ST_SETUP) begin
                a <= idx_nxt;
                d <= enc_din[idx_nxt];
            end
            n_le      <= (state_nxt != ST_STROBE);
            n_mr      <= (state_nxt != ST_CLEAR);
            bus.ready <= (state_nxt == ST_IDLE);
            bus.busy  <= (state_nxt != ST_IDLE);
            if (accept) begin
                din_r   <= bus.din;
                mask_r  <= bus.mask;
                wr_pend <= bus.valid && (bus.mask != 8'h00);
            end
        end
    end

endmodule

// File: tb/tb_latch259_writer.sv
module tb_latch259_writer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       sel = 1'b0;
    logic [7:0] din_v = '0, mask_v = '0;
    logic       valid_v = 1'b0, clr_v = 1'b0;

    latch259_writer_if if0 ();
    latch259_writer_if if1 ();

    assign if0.din   = din_v;
    assign if0.mask  = mask_v;
    assign if0.valid = valid_v && !sel;
    assign if0.clr   = clr_v && !sel;
    assign if1.din   = din_v;
    assign if1.mask  = mask_v;
    assign if1.valid = valid_v && sel;
    assign if1.clr   = clr_v && sel;

    logic [2:0] a0, a1;
    logic       d0, d1, nle0, nle1, nmr0, nmr1;

    latch259_writer dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave),
        .a(a0), .d(d0), .n_le(nle0), .n_mr(nmr0)
    );

    latch259_writer #(.SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave),
        .a(a1), .d(d1), .n_le(nle1), .n_mr(nmr1)
    );

    wire [2:0] o_a     = sel ? a1 : a0;
    wire       o_d     = sel ? d1 : d0;
    wire       o_nle   = sel ? nle1 : nle0;
    wire       o_nmr   = sel ? nmr1 : nmr0;
    wire       o_ready = sel ? if1.ready : if0.ready;
    wire       o_busy  = sel ? if1.busy : if0.busy;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] q_model = '0;

    typedef struct packed {
        logic [2:0] a;
        logic       d;
        logic       nle;
        logic       nmr;
        logic       chk_ad;
    } exp_t;

    typedef struct {
        logic [7:0] din;
        logic [7:0] mask;
        bit         valid;
        bit         clr;
        logic [7:0] pre;
        logic [7:0] exp_q;
        int         exp_busy;
        int         exp_strobes;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // 74HC259 behaviour on the currently observed outputs for one clock cycle.
    task automatic latch_cycle();
        if (!o_nmr) q_model = 8'h00;
        else if (!o_nle) q_model[o_a] = o_d;
    endtask

    task automatic run_txn(input logic [7:0] din_i, input logic [7:0] mask_i,
                           input bit valid_i, input bit clr_i,
                           input int s, input int p, input int h,
                           output int busy_cnt, output int strobes);
        exp_t q[$];
        exp_t e;
        int k;
        q = {};
        if (clr_i)
            for (int c = 0; c < p; c++) q.push_back('{a: 3'd0, d: 1'b0, nle: 1'b1, nmr: 1'b0, chk_ad: 1'b0});
        for (int i = 0; i < 8; i++) begin
            if (valid_i && mask_i[i]) begin
                for (int c = 0; c < s; c++) q.push_back('{a: 3'(i), d: din_i[i], nle: 1'b1, nmr: 1'b1, chk_ad: 1'b1});
                for (int c = 0; c < p; c++) q.push_back('{a: 3'(i), d: din_i[i], nle: 1'b0, nmr: 1'b1, chk_ad: 1'b1});
                for (int c = 0; c < h; c++) q.push_back('{a: 3'(i), d: din_i[i], nle: 1'b1, nmr: 1'b1, chk_ad: 1'b1});
            end
        end
        @(negedge clk);
        din_v = din_i; mask_v = mask_i; valid_v = valid_i; clr_v = clr_i;
        @(posedge clk); #1;
        valid_v = 1'b0; clr_v = 1'b0;
        busy_cnt = 0; strobes = 0; k = 0;
        while (o_busy && busy_cnt < 300) begin
            if (k < q.size()) begin
                e = q[k];
                if (e.chk_ad)
                    chk("trace", {o_ready, o_busy, o_a, o_d, o_nle, o_nmr},
                        {1'b0, 1'b1, e.a, e.d, e.nle, e.nmr});
                else
                    chk("trace_clr", {o_ready, o_busy, o_nle, o_nmr}, {1'b0, 1'b1, e.nle, e.nmr});
            end else begin
                chk("trace_overrun", 32'(k), 32'(q.size()));
            end
            if (!o_nle) strobes++;
            latch_cycle();
            k++; busy_cnt++;
            @(posedge clk); #1;
        end
        chk("busy_len", 32'(busy_cnt), 32'(q.size()));
        chk("idle_after", {o_ready, o_busy, o_nle, o_nmr}, 4'b1011);
        @(posedge clk); #1;
        chk("idle_hold", {o_ready, o_busy, o_nle, o_nmr}, 4'b1011);
    endtask

    initial begin
        vec_t tbl[5];
        int bc, st, pc;
        logic [7:0] din_r, mask_r, qexp;
        bit vr, cr;

        tbl[0] = '{din: 8'hA5, mask: 8'hFF, valid: 1, clr: 0, pre: 8'h00, exp_q: 8'hA5, exp_busy: 24, exp_strobes: 8};
        tbl[1] = '{din: 8'h00, mask: 8'h41, valid: 1, clr: 0, pre: 8'hFF, exp_q: 8'hBE, exp_busy: 6,  exp_strobes: 2};
        tbl[2] = '{din: 8'h80, mask: 8'h80, valid: 1, clr: 1, pre: 8'h3C, exp_q: 8'h80, exp_busy: 4,  exp_strobes: 1};
        tbl[3] = '{din: 8'hFF, mask: 8'h00, valid: 1, clr: 0, pre: 8'h77, exp_q: 8'h77, exp_busy: 0,  exp_strobes: 0};
        tbl[4] = '{din: 8'h00, mask: 8'hFF, valid: 0, clr: 1, pre: 8'h5A, exp_q: 8'h00, exp_busy: 1,  exp_strobes: 0};

        #12;
        chk("reset_dut0", {if0.ready, if0.busy, a0, d0, nle0, nmr0}, {1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1});
        chk("reset_dut1", {if1.ready, if1.busy, a1, d1, nle1, nmr1}, {1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1});
        #10 rst_n = 1'b1;

        for (int t = 0; t < 5; t++) begin
            q_model = tbl[t].pre;
            run_txn(tbl[t].din, tbl[t].mask, tbl[t].valid, tbl[t].clr, 1, 1, 1, bc, st);
            chk("tbl_q", 32'(q_model), 32'(tbl[t].exp_q));
            chk("tbl_busy", 32'(bc), 32'(tbl[t].exp_busy));
            chk("tbl_strobes", 32'(st), 32'(tbl[t].exp_strobes));
        end

        // Stretched phases on the second instance.
        sel = 1'b1;
        q_model = 8'h00;
        run_txn(8'h02, 8'h03, 1, 0, 2, 3, 1, bc, st);
        chk("slow_q", 32'(q_model), 32'h02);
        chk("slow_busy", 32'(bc), 32'd12);
        chk("slow_nle_low", 32'(st), 32'd6);
        sel = 1'b0;

        // Reset during the strobe of bit 3.
        @(negedge clk);
        din_v = 8'hFF; mask_v = 8'hFF; valid_v = 1'b1;
        @(posedge clk); #1;
        valid_v = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("pre_rst_strobe", {o_a, o_nle, o_busy}, {3'd3, 1'b0, 1'b1});
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", {o_ready, o_busy, o_a, o_d, o_nle, o_nmr}, {1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        q_model = 8'h00;
        run_txn(8'h20, 8'h28, 1, 0, 1, 1, 1, bc, st);
        chk("post_rst_q", 32'(q_model), 32'h20);
        chk("post_rst_busy", 32'(bc), 32'd6);

        // Random transactions against the rule-level expectation.
        for (int n = 0; n < 40; n++) begin
            din_r  = 8'($urandom);
            mask_r = 8'($urandom);
            vr = 1'($urandom);
            cr = ($urandom_range(0, 3) == 0);
            if (!vr && !cr) vr = 1'b1;
            q_model = 8'($urandom);
            qexp = cr ? 8'h00 : q_model;
            pc = cr ? 1 : 0;
            for (int i = 0; i < 8; i++)
                if (vr && mask_r[i]) begin
                    qexp[i] = din_r[i];
                    pc += 3;
                end
            run_txn(din_r, mask_r, vr, cr, 1, 1, 1, bc, st);
            chk("rand_q", 32'(q_model), 32'(qexp));
            chk("rand_busy", 32'(bc), 32'(pc));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
